// File: rtl/gtxe2_chnl_tx_oob.sv
// gtxe2_chnl_tx_oob
// OOB burst sequencer ahead of the GTXE2 TX serializer. A rising edge on
// txcominit / txcomwake plays burst_seq_len pairs of (burst_word burst,
// electrical-idle gap) into the serializer and then pulses txcomfinish.
// Outside a sequence, txdata / txelecidle pass through with one clock of latency.
// Optional feature macro: GTXE2_CHNL_TX_OOB_SAS_EN adds the txcomsas request
// and the sas_gap_len parameter.
module gtxe2_chnl_tx_oob #(
   parameter int              width         = 20,
   parameter int              burst_len     = 16,
   parameter int              init_gap_len  = 48,
   parameter int              wake_gap_len  = 16,
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
   parameter int              sas_gap_len   = 144,
`endif
   parameter int              burst_seq_len = 6,
   parameter logic [width-1:0] burst_word   = 20'hA8B53
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [width-1:0] txdata,
   input  logic             txelecidle,
   input  logic             txcominit,
   input  logic             txcomwake,
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
   input  logic             txcomsas,
`endif
   output logic [width-1:0] ser_data,
   output logic             ser_idle,
   output logic             txcomfinish,
   output logic             oob_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      KIND_INIT = 2'd0,
      KIND_WAKE = 2'd1,
      KIND_SAS  = 2'd2
   } kind_t;

   state_t             state_r, state_s;
   kind_t              kind_r, kind_s, start_kind_s;
   logic [15:0]        phase_r, phase_s;
   logic [3:0]         burst_cnt_r, burst_cnt_s;
   logic [3:0]         burst_inc_s;
   logic [15:0]        gap_last_s;
   logic               init_prev_r, wake_prev_r;
   logic               init_edge_s, wake_edge_s;
   logic               start_s;
   logic [width-1:0]   ser_data_r, ser_data_s;
   logic               ser_idle_r, ser_idle_s;
   logic               finish_r, finish_s;
   logic               busy_r, busy_s;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
   logic               sas_prev_r;
   logic               sas_edge_s;
`endif

   // Rising-edge detection: input high now, low on the previous clock.
   assign init_edge_s = txcominit & ~init_prev_r;
   assign wake_edge_s = txcomwake & ~wake_prev_r;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
   assign sas_edge_s  = txcomsas & ~sas_prev_r;
`endif

   assign burst_inc_s = burst_cnt_r + 4'd1;

   // Request arbitration: INIT beats WAKE beats SAS; losing edges are dropped.
   always_comb begin
      start_s      = 1'b0;
      start_kind_s = KIND_INIT;
      if (init_edge_s) begin
         start_s      = 1'b1;
         start_kind_s = KIND_INIT;
      end else if (wake_edge_s) begin
         start_s      = 1'b1;
         start_kind_s = KIND_WAKE;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
      end else if (sas_edge_s) begin
         start_s      = 1'b1;
         start_kind_s = KIND_SAS;
`endif
      end else begin
         start_s      = 1'b0;
         start_kind_s = KIND_INIT;
      end
   end

   // Last phase-counter value of a gap for the sequence kind in flight.
   always_comb begin
      gap_last_s = 16'(init_gap_len - 1);
      case (kind_r)
         KIND_INIT: gap_last_s = 16'(init_gap_len - 1);
         KIND_WAKE: gap_last_s = 16'(wake_gap_len - 1);
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
         KIND_SAS:  gap_last_s = 16'(sas_gap_len - 1);
`endif
         default:   gap_last_s = 16'(init_gap_len - 1);
      endcase
   end

   // Next-state logic plus next values of the registered serializer outputs.
   always_comb begin
      state_s     = state_r;
      kind_s      = kind_r;
      phase_s     = phase_r;
      burst_cnt_s = burst_cnt_r;
      finish_s    = 1'b0;
      ser_data_s  = txdata;
      ser_idle_s  = txelecidle;
      busy_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s     = ST_BURST;
               kind_s      = start_kind_s;
               phase_s     = 16'd0;
               burst_cnt_s = 4'd0;
            end else begin
               state_s     = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (phase_r == 16'(burst_len - 1)) begin
               state_s = ST_GAP;
               phase_s = 16'd0;
            end else begin
               phase_s = phase_r + 16'd1;
            end
         end
         ST_GAP: begin
            if (phase_r == gap_last_s) begin
               phase_s     = 16'd0;
               burst_cnt_s = burst_inc_s;
               if (burst_inc_s < 4'(burst_seq_len)) begin
                  state_s = ST_BURST;
               end else begin
                  state_s  = ST_IDLE;
                  finish_s = 1'b1;
               end
            end else begin
               phase_s = phase_r + 16'd1;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            phase_s     = 16'd0;
            burst_cnt_s = 4'd0;
         end
      endcase

      // Outputs follow the state being entered so they line up with it.
      case (state_s)
         ST_BURST: begin
            ser_data_s = burst_word;
            ser_idle_s = 1'b0;
            busy_s     = 1'b1;
         end
         ST_GAP: begin
            ser_data_s = '0;
            ser_idle_s = 1'b1;
            busy_s     = 1'b1;
         end
         default: begin
            ser_data_s = txdata;
            ser_idle_s = txelecidle;
            busy_s     = 1'b0;
         end
      endcase
   end

   // State, counters, edge history and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         kind_r      <= KIND_INIT;
         phase_r     <= 16'd0;
         burst_cnt_r <= 4'd0;
         init_prev_r <= 1'b1;
         wake_prev_r <= 1'b1;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
         sas_prev_r  <= 1'b1;
`endif
         ser_data_r  <= '0;
         ser_idle_r  <= 1'b1;
         finish_r    <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         kind_r      <= kind_s;
         phase_r     <= phase_s;
         burst_cnt_r <= burst_cnt_s;
         init_prev_r <= txcominit;
         wake_prev_r <= txcomwake;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
         sas_prev_r  <= txcomsas;
`endif
         ser_data_r  <= ser_data_s;
         ser_idle_r  <= ser_idle_s;
         finish_r    <= finish_s;
         busy_r      <= busy_s;
      end
   end

   assign ser_data    = ser_data_r;
   assign ser_idle    = ser_idle_r;
   assign txcomfinish = finish_r;
   assign oob_busy    = busy_r;

endmodule

// File: tb/tb_gtxe2_chnl_tx_oob.sv
// Directed bench for gtxe2_chnl_tx_oob with short bursts and gaps.
module tb_gtxe2_chnl_tx_oob;

   localparam int         W    = 20;
   localparam int         BL   = 4;
   localparam int         IGAP = 12;
   localparam int         WGAP = 4;
   localparam int         SEQ  = 6;
   localparam int         SGAP = 24;
   localparam logic [W-1:0] BW = 20'hA8B53;
   localparam logic [W-1:0] TXD = 20'h0F0F0;

   logic         clk;
   logic         reset;
   logic [W-1:0] txdata;
   logic         txelecidle;
   logic         txcominit;
   logic         txcomwake;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
   logic         txcomsas;
`endif
   logic [W-1:0] ser_data;
   logic         ser_idle;
   logic         txcomfinish;
   logic         oob_busy;

   int checks;
   int errors;

   gtxe2_chnl_tx_oob #(
      .width         (W),
      .burst_len     (BL),
      .init_gap_len  (IGAP),
      .wake_gap_len  (WGAP),
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
      .sas_gap_len   (SGAP),
`endif
      .burst_seq_len (SEQ),
      .burst_word    (BW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .txdata      (txdata),
      .txelecidle  (txelecidle),
      .txcominit   (txcominit),
      .txcomwake   (txcomwake),
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
      .txcomsas    (txcomsas),
`endif
      .ser_data    (ser_data),
      .ser_idle    (ser_idle),
      .txcomfinish (txcomfinish),
      .oob_busy    (oob_busy)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 = INIT, 1 = WAKE, 2 = INIT+WAKE together, 3 = SAS.
   // gap is the gap length the sequence is expected to use.
   // wake_at > 0 raises txcomwake at that sequence clock to show it is ignored.
   task automatic run_seq(input string name, input int kind, input int gap, input int wake_at);
      int   period;
      int   total;
      int   lows;
      int   pos;
      logic prev_idle;
      period    = BL + gap;
      total     = SEQ * period;
      lows      = 0;
      prev_idle = 1'b1;
      txcominit = (kind == 0) || (kind == 2);
      txcomwake = (kind == 1) || (kind == 2);
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
      txcomsas  = (kind == 3);
`endif
      for (int i = 1; i <= total + 2; i++) begin
         tick();
         if (i <= total) begin
            pos = (i - 1) % period;
            check_value($sformatf("%s busy@%0d", name, i), 32'(oob_busy), 32'd1);
            check_value($sformatf("%s finish@%0d", name, i), 32'(txcomfinish), 32'd0);
            check_value($sformatf("%s idle@%0d", name, i), 32'(ser_idle), 32'(pos >= BL));
            check_value($sformatf("%s data@%0d", name, i), 32'(ser_data),
                        (pos < BL) ? 32'(BW) : 32'd0);
            if (prev_idle && !ser_idle) lows++;
            prev_idle = ser_idle;
         end else if (i == total + 1) begin
            check_value($sformatf("%s finish@%0d", name, i), 32'(txcomfinish), 32'd1);
            check_value($sformatf("%s busy_end@%0d", name, i), 32'(oob_busy), 32'd0);
            check_value($sformatf("%s idle_end@%0d", name, i), 32'(ser_idle), 32'(txelecidle));
            check_value($sformatf("%s data_end@%0d", name, i), 32'(ser_data), 32'(TXD));
         end else begin
            check_value($sformatf("%s finish_once@%0d", name, i), 32'(txcomfinish), 32'd0);
            check_value($sformatf("%s no_retrigger@%0d", name, i), 32'(oob_busy), 32'd0);
         end
         if (i == 1) begin
            txcominit = 1'b0;
            txcomwake = 1'b0;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
            txcomsas  = 1'b0;
`endif
         end
         if (wake_at > 0 && i == wake_at) txcomwake = 1'b1;
         if (wake_at > 0 && i == wake_at + 1) txcomwake = 1'b0;
      end
      check_value({name, " low_runs"}, 32'(lows), 32'(SEQ));
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      txdata     = TXD;
      txelecidle = 1'b1;
      txcominit  = 1'b0;
      txcomwake  = 1'b0;
`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
      txcomsas   = 1'b0;
`endif
      #1;
      check_value("rst ser_data", 32'(ser_data), 32'd0);
      check_value("rst ser_idle", 32'(ser_idle), 32'd1);
      check_value("rst finish", 32'(txcomfinish), 32'd0);
      check_value("rst busy", 32'(oob_busy), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      tick();
      check_value("idle data pass", 32'(ser_data), 32'(TXD));

      run_seq("init", 0, IGAP, 0);
      tick();
      run_seq("wake", 1, WGAP, 0);
      tick();
      run_seq("both", 2, IGAP, 0);
      tick();
      run_seq("init_wake_ignored", 0, IGAP, 20);
      tick();

      // Reset in the middle of the first gap, with txcominit held high throughout.
      txcominit = 1'b1;
      for (int i = 1; i <= 8; i++) tick();
      check_value("pre_rst in_gap idle", 32'(ser_idle), 32'd1);
      check_value("pre_rst busy", 32'(oob_busy), 32'd1);
      reset = 1'b1;
      #1;
      check_value("mid_rst idle", 32'(ser_idle), 32'd1);
      check_value("mid_rst busy", 32'(oob_busy), 32'd0);
      check_value("mid_rst data", 32'(ser_data), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 1; i <= 110; i++) begin
         tick();
         check_value($sformatf("post_rst busy@%0d", i), 32'(oob_busy), 32'd0);
         check_value($sformatf("post_rst finish@%0d", i), 32'(txcomfinish), 32'd0);
      end
      txcominit = 1'b0;
      tick();

      // IDLE passthrough: new values visible one clock after they are applied.
      txdata     = 20'h12345;
      txelecidle = 1'b0;
      @(negedge clk);
      check_value("pass before data", 32'(ser_data), 32'(TXD));
      check_value("pass before idle", 32'(ser_idle), 32'd1);
      tick();
      check_value("pass data", 32'(ser_data), 32'h12345);
      check_value("pass idle", 32'(ser_idle), 32'd0);
      txdata     = TXD;
      txelecidle = 1'b1;
      tick();

`ifdef GTXE2_CHNL_TX_OOB_SAS_EN
      run_seq("sas", 3, SGAP, 0);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
